// File: rtl/dmem_resp.sv
// dmem_resp: word-wide data memory responder with byte enables and optional
// wait states; all outputs are registered.
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_rvld,
    output logic        o_busy,
    output logic        o_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;

    logic [31:0] rdata_q, rdata_d;
    logic        rvld_q, rvld_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          req;
    logic          perf;
    logic          use_cap;
    logic [31:0]   p_addr;
    logic [31:0]   p_wdata;
    logic [3:0]    p_mask;
    logic          p_ren;
    logic          p_wen;
    logic          p_oor;
    logic [AW-1:0] p_idx;

    assign req = (i_dmem_ren | i_dmem_wen) & ~i_rst;

    // Zero-wait accesses perform straight from the ports; waited ones from
    // the captured copy.
    assign p_addr  = use_cap ? addr_q  : i_dmem_addr;
    assign p_wdata = use_cap ? wdata_q : i_dmem_wdata;
    assign p_mask  = use_cap ? mask_q  : i_dmem_mask;
    assign p_ren   = use_cap ? ren_q   : i_dmem_ren;
    assign p_wen   = use_cap ? wen_q   : i_dmem_wen;
    assign p_idx   = p_addr[AW+1:2];
    assign p_oor   = (p_addr >> (AW + 2)) != 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        perf    = 1'b0;
        use_cap = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        perf = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                        busy_d  = 1'b1;
                        addr_d  = i_dmem_addr;
                        wdata_d = i_dmem_wdata;
                        mask_d  = i_dmem_mask;
                        ren_d   = i_dmem_ren;
                        wen_d   = i_dmem_wen;
                    end
                end
            end
            S_WAIT: begin
                use_cap = 1'b1;
                if (cnt_q == 4'd0) begin
                    perf    = ~i_rst;
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Response path: a read is suppressed when paired with a write.
    always_comb begin
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        err_d   = 1'b0;
        if (perf) begin
            err_d = (p_ren & p_wen) | p_oor;
            if (p_ren && !p_wen) begin
                rvld_d  = 1'b1;
                rdata_d = p_oor ? 32'd0 : mem_q[p_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            rdata_q <= 32'd0;
            rvld_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            err_q   <= err_d;
        end
    end

    // Storage is never reset; out-of-range writes are dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && perf && p_wen && !p_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (p_mask[b]) begin
                    mem_q[p_idx][8*b +: 8] <= p_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_dmem_rdata = rdata_q;
    assign o_dmem_rvld  = rvld_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule
